// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/opcode and result valid/ready handshakes for seq_alu
interface seq_alu_if #(parameter int N = 32);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alucontrol;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         overflow;
    modport master (output in_valid, alucontrol, a, b, out_ready,
                    input in_ready, out_valid, result, zero, overflow);
    modport slave  (input in_valid, alucontrol, a, b, out_ready,
                    output in_ready, out_valid, result, zero, overflow);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with single-cycle logic/arith ops and iterative MUL/SLL/SRL
module seq_alu #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t       r_state;
    logic [2:0]   r_op;
    logic [N-1:0] r_a, r_b, r_result;
    logic [SHW:0] r_cnt;
    logic         r_zero, r_ovf;
    logic [N-1:0] w_sum, w_diff, w_res, w_acc, w_step;
    logic [SHW-1:0] w_sh;
    logic         w_ovf;
    always_comb begin
        w_sum  = bus.a + bus.b;
        w_diff = bus.a - bus.b;
        w_sh   = bus.b[SHW-1:0];
        case (bus.alucontrol)
            3'b000:  w_res = bus.a & bus.b;
            3'b001:  w_res = bus.a | bus.b;
            3'b010:  w_res = w_sum;
            3'b110:  w_res = w_diff;
            3'b111:  w_res = {{(N-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            default: w_res = bus.a;
        endcase
        w_ovf  = (bus.alucontrol == 3'b010) ? (bus.a[N-1] == bus.b[N-1]) && (w_sum[N-1] != bus.a[N-1]) :
                 (bus.alucontrol == 3'b110) ? (bus.a[N-1] != bus.b[N-1]) && (w_diff[N-1] != bus.a[N-1]) : 1'b0;
        // MUL accumulates shifted multiplicand; shifts move one bit per step
        w_acc  = r_result + (r_b[0] ? r_a : '0);
        w_step = (r_op == 3'b011) ? w_acc : r_op[0] ? r_result >> 1 : r_result << 1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_op <= bus.alucontrol;
                    r_a  <= bus.a;
                    r_b  <= bus.b;
                    if (bus.alucontrol == 3'b011) begin
                        r_state  <= BUSY;
                        r_cnt    <= (SHW+1)'(N);
                        r_result <= '0;
                    end else if (bus.alucontrol[2:1] == 2'b10 && w_sh != '0) begin
                        r_state  <= BUSY;
                        r_cnt    <= {1'b0, w_sh};
                        r_result <= bus.a;
                    end else begin
                        r_state  <= DONE;
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_ovf    <= w_ovf;
                    end
                end
                BUSY: begin
                    r_result <= w_step;
                    r_a      <= r_a << 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_state <= DONE;
                        r_zero  <= (w_step == '0);
                        r_ovf   <= 1'b0;
                    end
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu
module tb_seq_alu;
    localparam logic [2:0] AND_OP = 3'b000, OR_OP = 3'b001, ADD_OP = 3'b010, MUL_OP = 3'b011;
    localparam logic [2:0] SLL_OP = 3'b100, SRL_OP = 3'b101, SUB_OP = 3'b110, SLT_OP = 3'b111;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   lat;
    logic ir_low;
    seq_alu_if #(.N(32)) bus ();
    seq_alu #(.N(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // latency counts edges from the accept edge (inclusive) until out_valid is seen
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int l, output logic irl);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alucontrol = op;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        l = 1;
        irl = 1'b1;
        while (!bus.out_valid && l < 200) begin
            irl &= !bus.in_ready;
            @(posedge clk);
            #1;
            l++;
        end
    endtask
    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask
    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.alucontrol = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_result", bus.result, 32'h0);
        chk("rst_flags", {30'b0, bus.zero, bus.overflow}, 32'h0);
        chk("rst_ready", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        issue(ADD_OP, 32'h7FFF_FFFF, 32'h0000_0001, lat, ir_low);
        chk("add_result", bus.result, 32'h8000_0000);
        chk("add_flags", {30'b0, bus.zero, bus.overflow}, 32'h1);
        chk("add_lat", lat, 1);
        consume();
        chk("add_release", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
        issue(SUB_OP, 32'd5, 32'd5, lat, ir_low);
        chk("sub_result", bus.result, 32'h0);
        chk("sub_flags", {30'b0, bus.zero, bus.overflow}, 32'h2);
        chk("sub_lat", lat, 1);
        consume();
        issue(SLT_OP, 32'hFFFF_FFFF, 32'h1, lat, ir_low);
        chk("slt_result", bus.result, 32'h1);
        chk("slt_zero", {31'b0, bus.zero}, 32'h0);
        chk("slt_lat", lat, 1);
        consume();
        issue(MUL_OP, 32'h0000_FFFF, 32'h0001_0001, lat, ir_low);
        chk("mul_result", bus.result, 32'hFFFF_FFFF);
        chk("mul_lat", lat, 33);
        chk("mul_busy_ready", {31'b0, ir_low}, 32'h1);
        chk("mul_flags", {30'b0, bus.zero, bus.overflow}, 32'h0);
        consume();
        issue(SLL_OP, 32'h1, 32'd31, lat, ir_low);
        chk("sll_result", bus.result, 32'h8000_0000);
        chk("sll_lat", lat, 32);
        consume();
        issue(SRL_OP, 32'h8000_0000, 32'd0, lat, ir_low);
        chk("srl0_result", bus.result, 32'h8000_0000);
        chk("srl0_lat", lat, 1);
        consume();
        issue(SRL_OP, 32'h8000_0000, 32'h0000_0124, lat, ir_low);
        chk("srl4_result", bus.result, 32'h0800_0000);
        chk("srl4_lat", lat, 5);
        consume();
        issue(AND_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, ir_low);
        chk("and_result", bus.result, 32'hF000_F000);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alucontrol = OR_OP;
        bus.a = 32'h1;
        bus.b = 32'h2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_result", bus.result, 32'hF000_F000);
            chk("bp_ready", {30'b0, bus.in_ready, bus.out_valid}, 32'h1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("bp_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("bp_accept", {30'b0, bus.in_ready, bus.out_valid}, 32'h1);
        chk("bp_pending_result", bus.result, 32'h3);
        consume();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alucontrol = MUL_OP;
        bus.a = 32'h1234;
        bus.b = 32'h5678;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mul_mid_valid", {31'b0, bus.out_valid}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_result", bus.result, 32'h0);
        chk("rst_mid_ready", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
        issue(OR_OP, 32'h0F, 32'hF0, lat, ir_low);
        chk("or_result", bus.result, 32'hFF);
        chk("or_lat", lat, 1);
        consume();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle ALU execution unit. It consumes the 3-bit alucontrol code produced by the ALU decoder, together with two operands.
- Operands and opcode arrive over a valid/ready handshake. Results leave over a second valid/ready handshake.
- Single-cycle logic and arithmetic ops, plus iterative MUL, SLL and SRL, share one FSM. The block sits in the execute stage, between the decoder/register-read logic and writeback.

Parameters:
- N, 32, operand and result width in bits (N >= 4, power of two).
- SHW, $clog2(N), shift-amount width; the shift amount is b[SHW-1:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- alucontrol  input  3  operation code (encoding under Behaviour).
- a  input  N  operand A.
- b  input  N  operand B; also the shift amount for SLL/SRL.
- out_valid  output  1  result, zero and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  N  registered result.
- zero  output  1  registered; 1 when result == 0.
- overflow  output  1  registered; signed overflow for ADD/SUB, 0 for all other ops.

Behaviour:
- Encoding:
  - 000 AND, 001 OR, 010 ADD, 011 MUL (low N bits of the product).
  - 100 SLL, 101 SRL (logical shift).
  - 110 SUB (a-b), 111 SLT (signed a<b gives 1, else 0).
  - All 8 codes are legal.
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are combinational decodes of registered state only.
- Accept:
  - An operation is accepted on a rising edge with in_valid && in_ready.
  - a, b and alucontrol are captured on that edge. Input values in any other cycle are ignored.
- Single-cycle ops (AND/OR/ADD/SUB/SLT):
  - The result is computed and registered on the accept edge.
  - IDLE->DONE, so out_valid rises after the accept edge (latency 1).
- MUL (shift-add, one multiplier bit per cycle):
  - IDLE->BUSY on the accept edge, with the iteration counter loaded to N.
  - Each BUSY edge performs one step and decrements the counter.
  - The step that takes the counter from 1 to 0 writes the final result and moves to DONE. Latency N+1 (33 for N=32).
- SLL/SRL (one bit per cycle):
  - Shift amount s = b[SHW-1:0].
  - If s == 0: IDLE->DONE with result = a (latency 1).
  - Otherwise: BUSY for s edges, shifting one bit per edge, then DONE. Latency s+1.
- DONE and output hold:
  - result, zero and overflow are stable for as long as out_valid is high.
  - If out_ready is high in DONE, the next edge goes DONE->IDLE. out_valid drops and in_ready rises in the same cycle.
  - There is no overlap: a new op is accepted at the earliest on the edge after IDLE is entered. Best-case 1-cycle-op throughput is one per 2 cycles.
- Backpressure: with out_ready low, DONE is held indefinitely. in_ready stays 0 and in_valid is ignored.
- Flags:
  - zero is computed from the final result only, never from intermediate BUSY values.
  - ADD overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]).
  - SUB overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]).
- Intermediate visibility: the result register may change during BUSY, but out_valid is 0 then.
- Reset:
  - rst_n low asynchronously forces IDLE, with result = 0, zero = 0, overflow = 0 and the counter cleared.
  - While reset is asserted, in_ready = 1 and out_valid = 0, but no accept occurs.
  - Reset mid-BUSY or mid-DONE aborts the operation; no result is ever presented for it.
- An out_ready pulse while not in DONE has no effect.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001:
  - result=0x80000000, overflow=1, zero=0.
  - out_valid one cycle after accept.
- SUB a=5, b=5, then SLT a=0xFFFFFFFF, b=1:
  - SUB gives result=0, zero=1, overflow=0.
  - SLT gives result=1, zero=0.
  - Each has latency 1.
- MUL a=0x0000FFFF, b=0x00010001:
  - result=0xFFFFFFFF.
  - out_valid rises exactly 33 cycles after accept; in_ready=0 throughout.
- Shift latency:
  - SLL a=1, b=31 gives result=0x80000000 with latency 32.
  - SRL a=0x80000000, b=0 gives result=0x80000000 with latency 1.
- Backpressure:
  - Finish an AND 0xF0F0F0F0 & 0xFF00FF00 (result=0xF000F000), then hold out_ready=0 for 5 cycles while driving in_valid=1 with another op.
  - Required: result stable, in_ready=0, no accept.
  - Then out_ready=1: IDLE next edge, and the pending op is accepted on the following edge.
- Reset during MUL:
  - Pulse rst_n low 10 cycles into a MUL: out_valid=0, result=0, in_ready=1 immediately.
  - After release, OR 0x0F | 0xF0 gives 0xFF with latency 1.
